// File: rtl/pmp_mem_arbiter.sv
// Arbitrates one single-outstanding memory port between the APF PMP bridge and a core requester.
// Bridge strobes are captured as pending jobs; every access is guarded by a timeout.
module pmp_mem_arbiter #(
    parameter int          AW       = 24,
    parameter logic [31:0] WIN_BASE = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK = 32'hFF00_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pmp_addr,
    input  logic          pmp_rd,
    input  logic          pmp_wr,
    input  logic [31:0]   pmp_wr_data,
    output logic [31:0]   pmp_rd_data,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_ack,
    output logic [31:0]   core_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          overrun,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, BR_ACC, CORE_ACC} state_t;
    typedef enum logic [1:0] {LG_NONE, LG_BR, LG_CORE} grant_t;

    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t          state, state_next;
    grant_t          last_grant;
    logic            br_pend;
    logic            br_we;
    logic [AW-1:0]   br_addr;
    logic [31:0]     br_wdata;
    logic [7:0]      tmo_cnt;
    logic            core_q;

    logic            strobe, in_window, capture, miss;
    logic            core_pend;
    logic            grant_br, grant_core, finish, abort;

    assign strobe    = pmp_rd | pmp_wr;
    assign in_window = (pmp_addr & WIN_MASK) == WIN_BASE;
    assign capture   = strobe & in_window;
    assign miss      = strobe & ~in_window;

    // The core request is seen one cycle late so it lines up with a bridge strobe captured
    // on the same cycle; the ack cycle is masked because the requester still holds core_req.
    assign core_pend = core_req & core_q & ~core_ack;

    always_comb begin
        state_next = state;
        grant_br   = 1'b0;
        grant_core = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (br_pend && core_pend) begin
                    if (last_grant == LG_BR) grant_core = 1'b1;
                    else                     grant_br   = 1'b1;
                end else if (br_pend) begin
                    grant_br = 1'b1;
                end else if (core_pend) begin
                    grant_core = 1'b1;
                end
                if (grant_br)        state_next = BR_ACC;
                else if (grant_core) state_next = CORE_ACC;
            end
            BR_ACC, CORE_ACC: begin
                if (mem_ack)                           finish = 1'b1;
                else if (tmo_cnt + 8'd1 == TMO_LIMIT)  abort  = 1'b1;
                if (finish || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= LG_NONE;
            br_pend     <= 1'b0;
            br_we       <= 1'b0;
            br_addr     <= '0;
            br_wdata    <= '0;
            tmo_cnt     <= '0;
            core_q      <= 1'b0;
            pmp_rd_data <= '0;
            core_ack    <= 1'b0;
            core_rdata  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            core_q   <= core_req;
            core_ack <= 1'b0;

            // A strobe landing on the grant edge is a fresh job, not an overwrite.
            if (capture) begin
                br_pend  <= 1'b1;
                br_we    <= pmp_wr;
                br_addr  <= pmp_addr[AW+1:2];
                br_wdata <= pmp_wr_data;
                if (br_pend && !grant_br) overrun <= 1'b1;
            end else if (grant_br) begin
                br_pend <= 1'b0;
            end

            if (grant_br) begin
                mem_req   <= 1'b1;
                mem_we    <= br_we;
                mem_addr  <= br_addr;
                mem_wdata <= br_wdata;
                tmo_cnt   <= '0;
            end else if (grant_core) begin
                mem_req   <= 1'b1;
                mem_we    <= core_we;
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
                tmo_cnt   <= '0;
            end else if (state != IDLE && !finish && !abort) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (finish || abort) begin
                mem_req <= 1'b0;
                if (abort) timeout_err <= 1'b1;
                if (state == BR_ACC) begin
                    last_grant <= LG_BR;
                    if (!mem_we) pmp_rd_data <= finish ? mem_rdata : ABORT_DATA;
                end else begin
                    last_grant <= LG_CORE;
                    core_ack   <= 1'b1;
                    core_rdata <= finish ? mem_rdata : ABORT_DATA;
                end
            end

            // Out-of-window reads complete immediately; being the newest read, they win.
            if (miss && pmp_rd && !pmp_wr) pmp_rd_data <= '0;
        end
    end

endmodule
